unified_mem_responder: RTL and testbench
========================================

// Module: unified_mem_responder
// PURPOSE
//   Memory-side responder for the multi-cycle RISC-V core's single unified instruction/data port.
//   Serves fetch, load and store requests from the core's memory-interface logic over a valid/ready
//   request channel and a one-cycle response pulse. Inserts a programmable number of wait states.
//   Flags misaligned or out-of-range accesses instead of performing them.
// PARAMETERS
//   DEPTH_WORDS  256  32-bit words of storage; word index = req_addr[31:2]
//   LATENCY      2    wait cycles between the accept cycle and the response cycle (0..15)
// PORTS
//   clk         in   1   rising-edge clock
//   reset_n     in   1   asynchronous, active-low reset
//   req_valid   in   1   request present; addr/write/wdata/wstrb held stable until accepted
//   req_write   in   1   1 = store, 0 = fetch/load
//   req_addr    in   32  byte address
//   req_wdata   in   32  store data
//   req_wstrb   in   4   byte enables for stores; bit i covers wdata[8i+7:8i]
//   req_ready   out  1   responder can accept a request this cycle
//   rsp_valid   out  1   one-cycle pulse: response for the outstanding request
//   rsp_rdata   out  32  read data; valid only while rsp_valid=1 and the request was a read
//   rsp_err     out  1   access rejected (misaligned or out of range); valid while rsp_valid=1
// BEHAVIOUR
//   Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, state IDLE, wait counter 0.
//     Storage array is not reset.
//   States:
//     IDLE -> (req_valid & req_ready) captures addr/write/wdata/wstrb;
//       goes to WAIT if LATENCY>0, otherwise to RESP.
//     WAIT -> counter loads LATENCY-1 on entry and decrements each cycle; goes to RESP when it is 0.
//     RESP -> for one cycle: rsp_valid=1 and the access is performed; then back to IDLE.
//   req_ready=1 only in IDLE, so there is at most one outstanding request. No pipelining.
//   Request inputs are ignored outside the accept cycle.
//   Latency: accept at cycle N -> rsp_valid at cycle N+1+LATENCY.
//     Back-to-back: next accept is no earlier than N+2+LATENCY.
//   Error rules, evaluated on the captured request:
//     misaligned = addr[1:0]!=0; out-of-range = addr[31:2] >= DEPTH_WORDS.
//     Either one -> rsp_err=1, rsp_rdata=0, no storage write.
//   Read: rsp_rdata = mem[addr[31:2]] during RESP, sampled combinationally from the array.
//   Write: performed on the clock edge that ends the RESP cycle; rsp_rdata=0 for writes.
//   A read in the cycle immediately after a write to the same word returns the new data.
//   Reset asserted mid-transaction (WAIT or RESP before its closing edge):
//     transaction abandoned, no write committed, no rsp_valid; state returns to IDLE.
//   rsp_valid must never be 1 for two consecutive cycles.
//   Because req_ready=0 during RESP, a request presented in that cycle is accepted in the next IDLE cycle.
//   LATENCY is clamped to 15; the counter is 4 bits wide.
// CONFIGURATION
//   BYTE_STRB_EN defined:
//     stores update only the bytes whose req_wstrb bit is 1; wstrb=4'b0000 is a legal no-op
//     store (rsp_err=0).
//   BYTE_STRB_EN undefined:
//     req_wstrb is ignored and every legal store writes all 32 bits.
//   Handshake timing and error rules are identical in both builds.
// TESTING
//   1. LATENCY=2. Store 0xDEADBEEF to 0x10 at cycle 5 -> rsp_valid=1 at cycle 8, err=0.
//      Load 0x10 -> rdata=0xDEADBEEF.
//   2. Load 0x13 -> rsp_err=1, rdata=0. Store to 0x400 with DEPTH_WORDS=256 -> err=1, and
//      a load of word 0 is unchanged.
//   3. BYTE_STRB_EN: word 0x20=0x11223344; store 0xAABBCCDD with wstrb=4'b0101 -> load gives 0x11BB33DD.
//      Without the macro, the same store gives 0xAABBCCDD.
//   4. LATENCY=0, req_valid held high for 4 requests -> accepts on alternate cycles, rsp_valid
//      pulses on alternate cycles, and req_ready is never 1 while a request is outstanding.
//   5. reset_n pulsed low during WAIT of a store to 0x30 -> no rsp_valid, word 0x30 unchanged,
//      req_ready=1 immediately.
//   6. Store 0x5A5A5A5A to 0x40, then a load of 0x40 accepted in the first IDLE cycle after the
//      response -> rdata=0x5A5A5A5A.

Source files
------------

// File: rtl/unified_mem_responder.sv
// Unified fetch/load/store responder: one request in flight, word storage with error flagging.
// Latency: accept at cycle N -> rsp_valid pulse at N+1+LATENCY (LATENCY clamped to 15).
// Backpressure: req_ready high only in IDLE; optional byte strobes via `define BYTE_STRB_EN.
module unified_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    // Effective wait count, limited to what the 4-bit counter can hold.
    localparam int          LAT_C    = (LATENCY > 15) ? 15 : ((LATENCY < 0) ? 0 : LATENCY);
    localparam logic [3:0]  CNT_LOAD = (LAT_C > 0) ? 4'(LAT_C - 1) : 4'd0;
    localparam int          AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [29:0] DEPTH_L  = 30'(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [3:0]    cnt_q;
    logic [3:0]    cnt_d;

    logic          cap_write;
    logic [31:0]   cap_addr;
    logic [31:0]   cap_wdata;
    logic [3:0]    wmask;

    logic          accept;
    logic          acc_err;
    logic          do_write;
    logic [AW-1:0] word_idx;

    logic [31:0]   mem [DEPTH_WORDS];

    assign accept = req_valid & req_ready;

`ifdef BYTE_STRB_EN
    logic [3:0] cap_wstrb;

    // Byte enables are held with the rest of the request until the response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_wstrb <= 4'd0;
        end else if (accept) begin
            cap_wstrb <= req_wstrb;
        end
    end

    assign wmask = cap_wstrb;
`else
    // Strobes have no effect in this build; every legal store writes the full word.
    logic unused_wstrb;
    assign unused_wstrb = ^req_wstrb;
    assign wmask        = 4'hF;
`endif

    // State and wait-counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: accept -> optional wait phase -> single response cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (LAT_C > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request fields are captured once, on the accept cycle; inputs are ignored afterwards.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_write <= 1'b0;
            cap_addr  <= 32'd0;
            cap_wdata <= 32'd0;
        end else if (accept) begin
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
        end
    end

    // Error classification and response outputs, all derived from the captured request.
    always_comb begin
        acc_err   = (cap_addr[1:0] != 2'b00) || (cap_addr[31:2] >= DEPTH_L);
        word_idx  = cap_addr[AW+1:2];
        req_ready = (state_q == IDLE);
        rsp_valid = (state_q == RESP);
        rsp_err   = rsp_valid && acc_err;
        do_write  = rsp_valid && cap_write && !acc_err;
        rsp_rdata = 32'd0;
        if (rsp_valid && !cap_write && !acc_err) begin
            rsp_rdata = mem[word_idx];
        end
    end

    // Store commits on the edge closing RESP; a reset before that edge leaves state IDLE, so nothing is written.
    always_ff @(posedge clk) begin
        if (do_write) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[word_idx][8*i +: 8] <= cap_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_unified_mem_responder.sv
module tb_unified_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // Main instance, LATENCY = 2
    logic        req_valid, req_write, req_ready, rsp_valid, rsp_err;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic [3:0]  req_wstrb;

    // LATENCY = 0 instance
    logic        v0, w0, ready0, rv0, re0;
    logic [31:0] a0, d0, rd0;
    logic [3:0]  s0;

    // LATENCY = 20 instance (clamped to 15)
    logic        vc, wc, readyc, rvc, rec;
    logic [31:0] ac, dc, rdc;
    logic [3:0]  sc;

    unified_mem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) u_dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    unified_mem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) u_lat0 (
        .clk(clk), .reset_n(reset_n), .req_valid(v0), .req_write(w0),
        .req_addr(a0), .req_wdata(d0), .req_wstrb(s0),
        .req_ready(ready0), .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0)
    );

    unified_mem_responder #(.DEPTH_WORDS(256), .LATENCY(20)) u_clamp (
        .clk(clk), .reset_n(reset_n), .req_valid(vc), .req_write(wc),
        .req_addr(ac), .req_wdata(dc), .req_wstrb(sc),
        .req_ready(readyc), .rsp_valid(rvc), .rsp_rdata(rdc), .rsp_err(rec)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A response pulse must never directly follow another one.
    logic prev_rv  = 1'b0;
    logic prev_rv0 = 1'b0;
    always @(negedge clk) begin
        if (rsp_valid) chk("rsp_not_consecutive", {31'd0, prev_rv}, 32'd0);
        if (rv0)       chk("rsp_not_consecutive_lat0", {31'd0, prev_rv0}, 32'd0);
        prev_rv  <= rsp_valid;
        prev_rv0 <= rv0;
    end

    // One complete transaction on the main instance; lat counts cycles from accept to response.
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: req_ready never rose for addr %h", a);
        end
        @(negedge clk);
        // Scramble inputs after acceptance; the responder must ignore them.
        req_valid = 1'b0; req_write = ~w; req_addr = $urandom; req_wdata = $urandom; req_wstrb = 4'($urandom);
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            chk("ready_while_busy", {31'd0, req_ready}, 32'd0);
            @(negedge clk);
            lat++;
        end
        rd = rsp_rdata;
        er = rsp_err;
        if (!rsp_valid) begin
            checks++; errors++;
            $display("FAIL rsp_timeout: no rsp_valid for addr %h", a);
        end
    endtask

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

`ifdef BYTE_STRB_EN
    localparam logic [31:0] EXP_STRB = 32'h11BB33DD;
`else
    localparam logic [31:0] EXP_STRB = 32'hAABBCCDD;
`endif

    logic [31:0] mm [int];

    initial begin
        vec_t        tbl[$];
        logic [31:0] rd;
        logic        er;
        int          lat;
        logic        seen;

        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        v0 = 0; w0 = 0; a0 = 0; d0 = 0; s0 = 0;
        vc = 0; wc = 0; ac = 0; dc = 0; sc = 0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_rsp_err",   {31'd0, rsp_err}, 32'd0);
        chk("reset_ready_lat0", {31'd0, ready0}, 32'd1);

        // Directed vectors: store/load, errors, strobes, read right after write, last word.
        tbl.push_back('{1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 32'hDEADBEEF, 1'b0});
        tbl.push_back('{1'b0, 32'h13,  32'h0,        4'h0, 32'h0,        1'b1});
        tbl.push_back('{1'b1, 32'h0,   32'h01020304, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h0,   32'h0,        4'h0, 32'h01020304, 1'b0});
        tbl.push_back('{1'b1, 32'h20,  32'h11223344, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b1, 32'h20,  32'hAABBCCDD, 4'h5, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h20,  32'h0,        4'h0, EXP_STRB,     1'b0});
        tbl.push_back('{1'b1, 32'h40,  32'h5A5A5A5A, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h40,  32'h0,        4'h0, 32'h5A5A5A5A, 1'b0});
        tbl.push_back('{1'b1, 32'h3FC, 32'hC0FFEE11, 4'hF, 32'h0,        1'b0});
        tbl.push_back('{1'b0, 32'h3FC, 32'h0,        4'h0, 32'hC0FFEE11, 1'b0});
        tbl.push_back('{1'b1, 32'h402, 32'h12121212, 4'hF, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'h2,   32'h0,        4'h0, 32'h0,        1'b1});
        tbl.push_back('{1'b0, 32'hFFFFFFFC, 32'h0,   4'h0, 32'h0,        1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            xact(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, rd, er, lat);
            chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
        end

        // Reset during WAIT of a store: nothing committed, ready immediately.
        xact(1'b1, 32'h30, 32'h12345678, 4'hF, rd, er, lat);
        chk("w30_err", {31'd0, er}, 32'd0);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_before_reset", {31'd0, req_ready}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("ready_in_reset_wait", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | rsp_valid;
        end
        chk("no_rsp_after_reset_wait", {31'd0, seen}, 32'd0);
        xact(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
        chk("w30_after_wait_reset", rd, 32'h12345678);

        // Reset during RESP of a store: pulse dropped, nothing committed.
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h0BADF00D; req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("in_resp_before_reset", {31'd0, rsp_valid}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rsp_dropped_in_reset", {31'd0, rsp_valid}, 32'd0);
        chk("ready_in_reset_resp", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        xact(1'b0, 32'h30, 32'h0, 4'h0, rd, er, lat);
        chk("w30_after_resp_reset", rd, 32'h12345678);

        // LATENCY=0 with req_valid held: accepts and pulses alternate.
        @(negedge clk);
        v0 = 1'b1; w0 = 1'b1; a0 = 32'h0; d0 = 32'h10000000; s0 = 4'hF;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("lat0_ready_k%0d", k), {31'd0, ready0}, {31'd0, (k % 2) == 0});
            chk($sformatf("lat0_rsp_k%0d", k), {31'd0, rv0}, {31'd0, (k % 2) == 1});
            if (k % 2 == 1) begin
                chk($sformatf("lat0_rdata_k%0d", k), rd0, (k == 9) ? 32'h10000002 : 32'h0);
                chk($sformatf("lat0_err_k%0d", k), {31'd0, re0}, 32'd0);
                if (k < 7) begin
                    a0 = 32'(4 * ((k + 1) / 2));
                    d0 = 32'h10000000 + 32'((k + 1) / 2);
                end else if (k == 7) begin
                    w0 = 1'b0; a0 = 32'h8;
                end else begin
                    v0 = 1'b0;
                end
            end
            @(negedge clk);
        end

        // LATENCY above 15 is clamped to 15.
        vc = 1'b1; wc = 1'b0; ac = 32'h3;
        @(negedge clk);
        vc = 1'b0;
        lat = 1;
        while (!rvc && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("clamp_latency", 32'(lat), 32'd16);
        chk("clamp_err", {31'd0, rec}, 32'd1);
        chk("clamp_rdata", rdc, 32'd0);

        // Random traffic against a word-array model; words 64..79 pre-filled so all reads are defined.
        for (int wd = 64; wd < 80; wd++) begin
            logic [31:0] dat;
            dat = $urandom;
            mm[wd] = dat;
            xact(1'b1, 32'(wd * 4), dat, 4'hF, rd, er, lat);
            chk("prefill_err", {31'd0, er}, 32'd0);
        end
        for (int i = 0; i < 80; i++) begin
            int          r;
            int          wd;
            logic [31:0] addr;
            logic [31:0] dat;
            logic [3:0]  st;
            logic        w;
            logic        ex_err;
            logic [31:0] ex_rd;
            r    = $urandom_range(0, 9);
            wd   = $urandom_range(64, 79);
            addr = 32'(wd * 4);
            if (r == 0) addr = addr | 32'($urandom_range(1, 3));
            if (r == 1) addr = ($urandom | 32'h00000400) & 32'hFFFFFFFC;
            w    = 1'($urandom_range(0, 1));
            dat  = $urandom;
            st   = 4'($urandom_range(0, 15));
            ex_err = (addr % 4 != 0) || ((addr / 4) >= 256);
            ex_rd  = 32'h0;
            if (!ex_err) begin
                if (w) begin
`ifdef BYTE_STRB_EN
                    for (int b = 0; b < 4; b++) begin
                        if (st[b]) mm[wd][8*b +: 8] = dat[8*b +: 8];
                    end
`else
                    mm[wd] = dat;
`endif
                end else begin
                    ex_rd = mm[wd];
                end
            end
            xact(w, addr, dat, st, rd, er, lat);
            chk($sformatf("rnd%0d_rdata", i), rd, ex_rd);
            chk($sformatf("rnd%0d_err", i), {31'd0, er}, {31'd0, ex_err});
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'd3);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
